// File: rtl/pipe_isqrt_pkg.sv
// Shared widths and the restoring square-root digit step used by every pipeline stage.
// The step works on a fixed wide word so any stage width can reuse it and truncate.
package pipe_isqrt_pkg;

    localparam int W_DEF  = 8;
    localparam int TW_DEF = 8;
    localparam int N      = W_DEF + 1;
    localparam int RW     = 2 * W_DEF + 2;
    localparam int REMW   = W_DEF + 3;
    localparam int MAXW   = 32;

    typedef logic [MAXW-1:0] word_t;

    typedef struct packed {
        word_t rem;
        word_t root;
    } step_t;

    // One root bit: bring down two radicand bits, try subtracting (4*root + 1).
    function automatic step_t isqrt_step(input word_t rem, input word_t root,
                                         input logic [1:0] two_bits);
        word_t r;
        word_t t;
        step_t s;
        r = (rem << 2) | word_t'(two_bits);
        t = (root << 2) | word_t'(1);
        if (r >= t) begin
            s.rem  = r - t;
            s.root = (root << 1) | word_t'(1);
        end else begin
            s.rem  = r;
            s.root = root << 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/pipe_isqrt_stage.sv
// One registered restoring-sqrt digit step carrying valid, shifted radicand, partial
// remainder, partial root and the sideband tag.
module pipe_isqrt_stage #(
    parameter int W  = 8,
    parameter int TW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           prev_valid,
    input  logic [2*W+1:0] prev_rad,
    input  logic [W+2:0]   prev_rem,
    input  logic [W:0]     prev_root,
    input  logic [TW-1:0]  prev_tag,
    output logic           valid,
    output logic [2*W+1:0] rad,
    output logic [W+2:0]   rem,
    output logic [W:0]     root,
    output logic [TW-1:0]  tag
);
    import pipe_isqrt_pkg::*;

    step_t step;
    logic  unused_hi;

    assign step = isqrt_step(word_t'(prev_rem), word_t'(prev_root), prev_rad[2*W+1 -: 2]);
    // Upper bits of the wide step are always zero for a valid radicand.
    assign unused_hi = ^{step.rem[MAXW-1:W+3], step.root[MAXW-1:W+1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            tag   <= '0;
        end else if (en) begin
            valid <= prev_valid;
            rad   <= {prev_rad[2*W-1:0], 2'b00};
            rem   <= step.rem[W+2:0];
            root  <= step.root[W:0];
            tag   <= prev_tag;
        end
    end

endmodule

// File: rtl/pipe_isqrt.sv
// Pipelined restoring integer square root, one root bit per stage, with
// bubble-collapsing valid/ready backpressure; the last stage drives the outputs.
module pipe_isqrt #(
    parameter int W  = 8,
    parameter int TW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W+1:0] in_s2,
    input  logic [TW-1:0]  in_tag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     out_root,
    output logic [W+1:0]   out_rem,
    output logic [TW-1:0]  out_tag
);
    import pipe_isqrt_pkg::*;

    localparam int NS = W + 1;

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [NS:0]    vld_c;
    logic [2*W+1:0] rad_c  [NS+1];
    logic [W+2:0]   rem_c  [NS+1];
    logic [W:0]     root_c [NS+1];
    logic [TW-1:0]  tag_c  [NS+1];
    logic [NS-1:0]  en;
    logic           unused_top;

    assign vld_c[0]  = in_valid;
    assign rad_c[0]  = in_s2;
    assign rem_c[0]  = '0;
    assign root_c[0] = '0;
    assign tag_c[0]  = in_tag;

    for (genvar k = 0; k < NS; k++) begin : g_stage
        // A stage may load if it or any stage downstream has a hole, or the output drains.
        assign en[k] = out_ready | ~(&vld_c[NS:k+1]);

        pipe_isqrt_stage #(.W(W), .TW(TW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en[k]),
            .prev_valid(vld_c[k]),
            .prev_rad  (rad_c[k]),
            .prev_rem  (rem_c[k]),
            .prev_root (root_c[k]),
            .prev_tag  (tag_c[k]),
            .valid     (vld_c[k+1]),
            .rad       (rad_c[k+1]),
            .rem       (rem_c[k+1]),
            .root      (root_c[k+1]),
            .tag       (tag_c[k+1])
        );
    end

    assign in_ready  = en[0];
    assign out_valid = vld_c[NS];
    assign out_root  = root_c[NS];
    // Final remainder is at most 2*root, so its top bit is always zero.
    assign out_rem    = rem_c[NS][W+1:0];
    assign out_tag    = tag_c[NS];
    assign unused_top = ^{rem_c[NS][W+2], rad_c[NS]};

endmodule
